// File: rtl/count_obs_pkg.sv
// Shared definitions for the count observation path.
// Contents:
//   DataW     - default width of the observed counter value
//   FrameBits - serial bits per frame: start + DataW data + parity + stop
//   state_e   - serializer FSM states
package count_obs_pkg;

  localparam int unsigned DataW     = 4;
  localparam int unsigned FrameBits = DataW + 3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

endpackage

// File: rtl/bit_timer.sv
// Divide-by-ClksPerBit bit timer for the serializer.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   clr_i  - holds the counter at zero, so the next bit starts on a full period
//   tick_o - high on the last cycle of each bit period
module bit_timer #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = cnt_q + CntW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_serializer.sv
// Watches a counter value, captures each change into a one-deep pending buffer
// and ships it out as a UART-style frame: start(0), data LSB first, even
// parity, stop(1). Values overwritten before transmission are counted.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   en          - change-capture enable (a frame in flight always completes)
//   count_in    - observed counter value
//   tx          - serial line, idles high (registered)
//   busy        - high while the serializer is not idle (registered)
//   frame_done  - one-cycle pulse on the last cycle of the stop bit
//   overrun_cnt - saturating count of overwritten pending values
module count_serializer
  import count_obs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = DataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] count_in,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned IdxW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] last_seen_q;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic bit_tick;
  logic consume;
  logic change;

  // Timer held at zero while idle so START always lasts a full bit period.
  bit_timer #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q == StIdle),
    .tick_o(bit_tick)
  );

  assign change = en && (count_in != last_seen_q);

  // FSM next state and frame datapath
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    consume   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          consume   = 1'b1;
          shift_d   = pend_data_q;
          parity_d  = ^pend_data_q;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LastIdx) begin
            state_d = StParity;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending buffer and overrun counter. A change in the consume cycle simply
  // refills the buffer; only an overwrite of an unconsumed value is an overrun.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;
    if (consume) begin
      pend_valid_d = 1'b0;
    end
    if (change) begin
      pend_valid_d = 1'b1;
      pend_data_d  = count_in;
      if (pend_valid_q && !consume && (overrun_q != 8'hFF)) begin
        overrun_d = overrun_q + 8'd1;
      end
    end
  end

  // Outputs are decoded from the current state and registered, so the line
  // trails the FSM by one cycle.
  always_comb begin
    tx_d         = 1'b1;
    busy_d       = (state_q != StIdle);
    frame_done_d = (state_q == StStop) && bit_tick;
    unique case (state_q)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = parity_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_seen_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_idx_q    <= '0;
      overrun_q    <= 8'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_seen_q  <= count_in;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_idx_q    <= bit_idx_d;
      overrun_q    <= overrun_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun_cnt = overrun_q;

endmodule
